// File: rtl/accum_bcd_disp_pkg.sv
// Shared types and constants for the accumulator / 7-segment display driver:
// FSM state encoding, segment lookup table and digit-count helper.
package accum_bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_CONV = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  // Segment codes gfedcba, active-high, for decimal digits 0..9.
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Middle bar only; shown for a code that is not a decimal digit.
  localparam logic [6:0] SEG_DASH = 7'h40;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    if (digit > 4'd9) return SEG_DASH;
    return SEG_LUT[digit];
  endfunction

  // Number of decimal digits needed to print the largest value of 'bits' bits.
  function automatic int bcd_digits(input int bits);
    longint unsigned v;
    int n;
    v = (64'd1 << bits) - 64'd1;
    n = 0;
    while (v != 0) begin
      v = v / 10;
      n = n + 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/accum_bcd_disp_axis_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// One input bit is consumed per clock; a conversion takes BW cycles after the
// start pulse, ending with a single-cycle done pulse while bcd is valid.
module bin2bcd_seq #(
  parameter int BW = 12,
  parameter int ND = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [BW-1:0]        bin,
  output logic                 busy,
  output logic                 done,
  output logic [ND-1:0][3:0]   bcd
);

  localparam int CNTW = $clog2(BW + 1);

  logic [BW-1:0]      sr;
  logic [CNTW-1:0]    cnt;
  logic [ND-1:0][3:0] adj;
  logic [ND*4-1:0]    adj_flat;
  logic [ND*4-1:0]    bcd_next;

  // Add-3 correction on every digit >= 5, then shift in the next binary bit.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < ND; i++) begin
      if (bcd[i] >= 4'd5) adj[i] = bcd[i] + 4'd3;
    end
    adj_flat = adj;
    bcd_next = {adj_flat[ND*4-2:0], sr[BW-1]};
  end

  // Load on start, then iterate once per clock until all BW bits are consumed.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr   <= '0;
      cnt  <= '0;
      bcd  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr   <= bin;
        bcd  <= '0;
        cnt  <= CNTW'(BW);
        busy <= 1'b1;
      end else if (busy) begin
        bcd <= bcd_next;
        sr  <= {sr[BW-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CNTW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/accum_bcd_disp_axis.sv
// AXI-stream accumulator / 7-segment display driver.
// Sums a frame of up to N samples, converts the sum to decimal and presents
// the digits as 7-segment codes on a valid/ready master stream.
// Optional: ACCUM_BCD_BLANK_LEADING_ZERO_EN blanks leading zero digits
// above the units digit.
module accum_bcd_disp_axis
  import accum_bcd_disp_pkg::*;
#(
  parameter int N       = 10,
  parameter int WIDTH   = 8,
  parameter int NDIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WIDTH-1:0]            s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [NDIGITS-1:0][6:0]     m_data,
  output logic                        m_ovf,
  output logic [$clog2(N+1)-1:0]      m_count
);

  localparam int SW     = WIDTH + $clog2(N);
  localparam int CW     = $clog2(N + 1);
  localparam int NB     = bcd_digits(SW);
  // Converter spans every digit SW bits can reach, and at least NDIGITS.
  localparam int ND_INT = (NB > NDIGITS) ? NB : NDIGITS;

  state_t                 state;
  logic [SW-1:0]          sum;
  logic [CW-1:0]          count;
  logic                   conv_start;
  logic                   conv_busy;
  logic                   conv_done;
  logic [ND_INT-1:0][3:0] bcd;
  logic                   ovf;
  logic [NDIGITS-1:0][6:0] disp;
  logic                   accept;
  logic                   frame_end;

  assign s_ready   = (state == ST_RX);
  assign m_valid   = (state == ST_TX);
  assign accept    = s_valid && s_ready;
  assign frame_end = (count == CW'(N - 1)) || s_last;

  bin2bcd_seq #(
    .BW (SW),
    .ND (ND_INT)
  ) u_bin2bcd (
    .clk   (clk),
    .rstn  (rstn),
    .start (conv_start),
    .bin   (sum),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Overflow detection and segment encoding of the low NDIGITS digits.
  always_comb begin
    ovf  = 1'b0;
    disp = '0;
    for (int i = NDIGITS; i < ND_INT; i++) begin
      if (bcd[i] != 4'd0) ovf = 1'b1;
    end
`ifdef ACCUM_BCD_BLANK_LEADING_ZERO_EN
    begin
      // A digit is blank only if it and every digit above it (hidden ones too) are zero.
      logic nz_above;
      nz_above = ovf;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
        if (i != 0 && !nz_above && bcd[i] == 4'd0) disp[i] = 7'h00;
        else                                       disp[i] = seg_encode(bcd[i]);
        nz_above = nz_above || (bcd[i] != 4'd0);
      end
    end
`else
    for (int i = 0; i < NDIGITS; i++) begin
      disp[i] = seg_encode(bcd[i]);
    end
`endif
  end

  // Frame FSM: accumulate in RX, convert in CONV, hold the word in TX.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_RX;
      sum        <= '0;
      count      <= '0;
      conv_start <= 1'b0;
      m_data     <= '0;
      m_ovf      <= 1'b0;
      m_count    <= '0;
    end else begin
      conv_start <= 1'b0;
      case (state)
        ST_RX: begin
          if (accept) begin
            sum   <= sum + SW'(s_data);
            count <= count + 1'b1;
            if (frame_end) begin
              state      <= ST_CONV;
              conv_start <= 1'b1;
            end
          end
        end
        ST_CONV: begin
          if (conv_done && !conv_busy) begin
            m_data  <= disp;
            m_ovf   <= ovf;
            m_count <= count;
            state   <= ST_TX;
          end
        end
        ST_TX: begin
          if (m_ready) begin
            state <= ST_RX;
            sum   <= '0;
            count <= '0;
          end
        end
        default: state <= ST_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_bcd_disp_axis.sv
// Directed testbench for accum_bcd_disp_axis: a default instance (NDIGITS=4)
// and a 3-digit instance share the same stimulus.
module tb_accum_bcd_disp_axis;

`ifdef ACCUM_BCD_BLANK_LEADING_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [3:0][6:0] m_data;
  logic        m_ovf;
  logic [3:0]  m_count;

  logic        s_ready3;
  logic        m_valid3;
  logic [2:0][6:0] m_data3;
  logic        m_ovf3;
  logic [3:0]  m_count3;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  always #5 clk = ~clk;

  accum_bcd_disp_axis #(.N(10), .WIDTH(8), .NDIGITS(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_ovf   (m_ovf),
    .m_count (m_count)
  );

  accum_bcd_disp_axis #(.N(10), .WIDTH(8), .NDIGITS(3)) dut3 (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready3),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid3),
    .m_ready (m_ready),
    .m_data  (m_data3),
    .m_ovf   (m_ovf3),
    .m_count (m_count3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one sample and return #1 after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Count edges until m_valid is seen high, bounded.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!m_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!m_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      s_data = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("post_hs_m_valid", 32'(m_valid), 32'd0);
    check("post_hs_s_ready", 32'(s_ready), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data",  32'(m_data),  32'd0);
    check("rst_m_ovf",   32'(m_ovf),   32'd0);
    check("rst_m_count", 32'(m_count), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Frame 1: samples 1..10, full frame, m_ready held high.
    m_ready = 1'b1;
    for (int i = 1; i <= 10; i++) send(8'(i), 1'b0);
    check("f1_conv_s_ready", 32'(s_ready), 32'd0);
    wait_valid(lat);
    check("f1_latency", 32'(lat), 32'd14);
    check("f1_m_data", 32'(m_data), BLANK ? 32'({7'h00, 7'h00, 7'h6D, 7'h6D})
                                          : 32'({7'h3F, 7'h3F, 7'h6D, 7'h6D}));
    check("f1_m_ovf",   32'(m_ovf),   32'd0);
    check("f1_m_count", 32'(m_count), 32'd10);
    @(posedge clk); #1;
    m_ready = 1'b0;
    check("f1_after_m_valid", 32'(m_valid), 32'd0);
    check("f1_after_s_ready", 32'(s_ready), 32'd1);

    // Frame 2: ten samples of 255 -> 2550; 3-digit instance overflows.
    for (int i = 0; i < 10; i++) send(8'd255, 1'b0);
    wait_valid(lat);
    check("f2_latency", 32'(lat), 32'd14);
    check("f2_m_data", 32'(m_data), 32'({7'h5B, 7'h6D, 7'h6D, 7'h3F}));
    check("f2_m_ovf",  32'(m_ovf),  32'd0);
    check("f2_m_count", 32'(m_count), 32'd10);
    check("f2_nd3_valid", 32'(m_valid3), 32'd1);
    check("f2_nd3_m_data", 32'(m_data3), 32'({7'h6D, 7'h6D, 7'h3F}));
    check("f2_nd3_m_ovf", 32'(m_ovf3), 32'd1);

    // Backpressure: hold m_ready low with a sample offered.
    s_valid = 1'b1;
    s_data  = 8'd99;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_m_valid", 32'(m_valid), 32'd1);
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_m_data",  32'(m_data),  32'({7'h5B, 7'h6D, 7'h6D, 7'h3F}));
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("bp_hs_m_valid", 32'(m_valid), 32'd0);
    check("bp_hs_s_ready", 32'(s_ready), 32'd1);

    // Frame 3: 7, 8, 9 with s_last -> 24; also proves the offered 99 was not absorbed.
    send(8'd7, 1'b0);
    send(8'd8, 1'b0);
    send(8'd9, 1'b1);
    wait_valid(lat);
    check("f3_latency", 32'(lat), 32'd14);
    check("f3_m_data", 32'(m_data), BLANK ? 32'({7'h00, 7'h00, 7'h5B, 7'h66})
                                          : 32'({7'h3F, 7'h3F, 7'h5B, 7'h66}));
    check("f3_m_count", 32'(m_count), 32'd3);
    check("f3_m_ovf",   32'(m_ovf),   32'd0);
    handshake();

    // Frame 4: ten samples of 3 with random idle gaps -> 30.
    for (int i = 0; i < 10; i++) begin
      idle(int'($urandom_range(0, 3)));
      send(8'd3, 1'b0);
    end
    wait_valid(lat);
    check("f4_m_data", 32'(m_data), BLANK ? 32'({7'h00, 7'h00, 7'h4F, 7'h3F})
                                          : 32'({7'h3F, 7'h3F, 7'h4F, 7'h3F}));
    check("f4_m_count", 32'(m_count), 32'd10);
    handshake();

    // Reset during CONV, then a fresh 1+2 frame.
    send(8'd50, 1'b0);
    send(8'd60, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_s_ready", 32'(s_ready), 32'd1);
    check("midrst_m_data",  32'(m_data),  32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(20);
    check("midrst_no_stray_valid", 32'(m_valid), 32'd0);
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    wait_valid(lat);
    check("f5_latency", 32'(lat), 32'd14);
    check("f5_m_data", 32'(m_data), BLANK ? 32'({7'h00, 7'h00, 7'h00, 7'h4F})
                                          : 32'({7'h3F, 7'h3F, 7'h3F, 7'h4F}));
    check("f5_m_count", 32'(m_count), 32'd2);
    handshake();

    // Single-sample frame of value 0.
    send(8'd0, 1'b1);
    wait_valid(lat);
    check("f6_m_data", 32'(m_data), BLANK ? 32'({7'h00, 7'h00, 7'h00, 7'h3F})
                                          : 32'({7'h3F, 7'h3F, 7'h3F, 7'h3F}));
    check("f6_m_count", 32'(m_count), 32'd1);
    check("f6_m_ovf",   32'(m_ovf),   32'd0);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
